// File: rtl/hazard_ctrl.sv
// Front-end hazard control: decides per cycle whether PC, IF/ID and ID/EX advance,
// stall, take a bubble or squash wrong-path work, and counts stall/flush activity.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             UsesRt_IF_ID,
    input  logic             MemRead_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic             BranchTaken_EX,
    input  logic             J_ID_EX,
    input  logic             JAL_ID_EX,
    input  logic             JR_ID_EX,
    input  logic             MemBusy,
    output logic             Enable_PC,
    output logic             Enable_IF_ID,
    output logic             Enable_ID_EX,
    output logic             Flush_IF_ID,
    output logic             Flush_ID_EX,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             redirect;
    logic             load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign redirect = BranchTaken_EX | J_ID_EX | JAL_ID_EX | JR_ID_EX;
    assign load_use = MemRead_ID_EX && (Rt_ID_EX != 5'd0) &&
                      ((Rt_ID_EX == Rs_IF_ID) || (UsesRt_IF_ID && (Rt_ID_EX == Rt_IF_ID)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        Enable_PC    = 1'b1;
        Enable_IF_ID = 1'b1;
        Enable_ID_EX = 1'b1;
        Flush_IF_ID  = 1'b0;
        Flush_ID_EX  = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_d      = stall_q;
        flush_d      = flush_q;

        if (MemBusy) begin
            // Freeze holds ID/EX, so a pending redirect is seen again once memory is ready.
            Enable_PC    = 1'b0;
            Enable_IF_ID = 1'b0;
            Enable_ID_EX = 1'b0;
            stall_d      = sat_inc(stall_q);
        end else if (state_q == FLUSH) begin
            Enable_PC   = 1'b0;
            Flush_IF_ID = 1'b1;
            Flush_ID_EX = 1'b1;
            stall_d     = sat_inc(stall_q);
            if (cnt_q <= 4'd1) begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (redirect) begin
            Flush_IF_ID = 1'b1;
            Flush_ID_EX = 1'b1;
            flush_d     = sat_inc(flush_q);
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = CNT_INIT;
            end
        end else if (load_use) begin
            Enable_PC    = 1'b0;
            Enable_IF_ID = 1'b0;
            Flush_ID_EX  = 1'b1;
            stall_d      = sat_inc(stall_q);
        end

        if (reset) begin
            Enable_PC    = 1'b0;
            Enable_IF_ID = 1'b0;
            Enable_ID_EX = 1'b0;
            Flush_IF_ID  = 1'b0;
            Flush_ID_EX  = 1'b0;
        end
    end

    assign State      = state_q;
    assign StallCount = stall_q;
    assign FlushCount = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (3-cycle penalty / 32-bit counters and
// single-cycle squash / 4-bit counters) checked each cycle against a penalty-budget model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs = '0, rt = '0, rt_ex = '0;
    logic       uses_rt = 1'b0, memread = 1'b0, br = 1'b0, j = 1'b0, jal = 1'b0, jr = 1'b0;
    logic       membusy = 1'b0;

    logic        a_pc, a_if, a_ex, a_fif, a_fex;
    logic [1:0]  a_st;
    logic [31:0] a_sc, a_fc;
    logic        b_pc, b_if, b_ex, b_fif, b_fex;
    logic [1:0]  b_st;
    logic [3:0]  b_sc, b_fc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .Rs_IF_ID(rs), .Rt_IF_ID(rt), .UsesRt_IF_ID(uses_rt),
        .MemRead_ID_EX(memread), .Rt_ID_EX(rt_ex), .BranchTaken_EX(br),
        .J_ID_EX(j), .JAL_ID_EX(jal), .JR_ID_EX(jr), .MemBusy(membusy),
        .Enable_PC(a_pc), .Enable_IF_ID(a_if), .Enable_ID_EX(a_ex),
        .Flush_IF_ID(a_fif), .Flush_ID_EX(a_fex), .State(a_st),
        .StallCount(a_sc), .FlushCount(a_fc));

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .Rs_IF_ID(rs), .Rt_IF_ID(rt), .UsesRt_IF_ID(uses_rt),
        .MemRead_ID_EX(memread), .Rt_ID_EX(rt_ex), .BranchTaken_EX(br),
        .J_ID_EX(j), .JAL_ID_EX(jal), .JR_ID_EX(jr), .MemBusy(membusy),
        .Enable_PC(b_pc), .Enable_IF_ID(b_if), .Enable_ID_EX(b_ex),
        .Flush_IF_ID(b_fif), .Flush_ID_EX(b_fex), .State(b_st),
        .StallCount(b_sc), .FlushCount(b_fc));

    // Model: per instance, bubble cycles still owed after a redirect, plus event tallies.
    int     pen    [2] = '{3, 1};
    longint cmax   [2] = '{64'hFFFF_FFFF, 15};
    int     owed   [2] = '{0, 0};
    longint m_stall[2] = '{0, 0};
    longint m_flush[2] = '{0, 0};

    function automatic logic hz_redirect();
        return br | j | jal | jr;
    endfunction

    function automatic logic hz_loaduse();
        return memread && rt_ex != 0 && (rt_ex == rs || (uses_rt && rt_ex == rt));
    endfunction

    // {Enable_PC, Enable_IF_ID, Enable_ID_EX, Flush_IF_ID, Flush_ID_EX}
    function automatic logic [4:0] exp_ctl(int k);
        if (reset)              return 5'b00000;
        if (membusy)            return 5'b00000;
        if (owed[k] > 0)        return 5'b01111;
        if (hz_redirect())      return 5'b11111;
        if (hz_loaduse())       return 5'b00101;
        return 5'b11100;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                owed[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (membusy) begin
                    m_stall[k] = (m_stall[k] < cmax[k]) ? m_stall[k] + 1 : m_stall[k];
                end else if (owed[k] > 0) begin
                    m_stall[k] = (m_stall[k] < cmax[k]) ? m_stall[k] + 1 : m_stall[k];
                    owed[k] = owed[k] - 1;
                end else if (hz_redirect()) begin
                    m_flush[k] = (m_flush[k] < cmax[k]) ? m_flush[k] + 1 : m_flush[k];
                    owed[k] = pen[k] - 1;
                end else if (hz_loaduse()) begin
                    m_stall[k] = (m_stall[k] < cmax[k]) ? m_stall[k] + 1 : m_stall[k];
                end
            end
        end
    end

    task automatic cmp(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("a_ctl",   {a_pc, a_if, a_ex, a_fif, a_fex}, exp_ctl(0));
        cmp("a_state", a_st, (owed[0] > 0) ? 1 : 0);
        cmp("a_stall", a_sc, m_stall[0]);
        cmp("a_flush", a_fc, m_flush[0]);
        cmp("b_ctl",   {b_pc, b_if, b_ex, b_fif, b_fex}, exp_ctl(1));
        cmp("b_state", b_st, (owed[1] > 0) ? 1 : 0);
        cmp("b_stall", b_sc, m_stall[1]);
        cmp("b_flush", b_fc, m_flush[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_ctl(string name, logic [4:0] exp);
        #1;
        cmp(name, {a_pc, a_if, a_ex, a_fif, a_fex}, exp);
    endtask

    initial begin
        #1 reset = 1'b1;
        tick(); tick();
        lit_ctl("rst_ctl", 5'b00000);
        cmp("rst_state", a_st, 0);
        cmp("rst_stall", a_sc, 0);
        reset = 1'b0;
        lit_ctl("post_rst_ctl", 5'b11100);
        repeat (10) tick();
        lit_ctl("idle_ctl", 5'b11100);
        cmp("idle_stall", a_sc, 0);
        cmp("idle_flush", a_fc, 0);

        // Load-use on Rs, then bubble clears MemRead
        memread = 1; rt_ex = 8; rs = 8;
        lit_ctl("lu_rs_ctl", 5'b00101);
        tick(); memread = 0;
        lit_ctl("lu_after_ctl", 5'b11100);
        cmp("lu_stall1", a_sc, 1);
        // Destination r0 never stalls
        memread = 1; rt_ex = 0; rs = 0;
        lit_ctl("lu_r0_ctl", 5'b11100);
        tick(); memread = 0;
        cmp("lu_r0_stall", a_sc, 1);
        // Rt match only counts when the instruction reads Rt
        memread = 1; rt_ex = 5; rs = 3; rt = 5; uses_rt = 1;
        lit_ctl("lu_rt_ctl", 5'b00101);
        tick(); uses_rt = 0;
        lit_ctl("lu_rt_unused_ctl", 5'b11100);
        tick(); memread = 0;
        cmp("lu_stall2", a_sc, 2);

        // Jump: squash cycle, two FLUSH cycles, back to RUN
        j = 1;
        lit_ctl("j_squash_ctl", 5'b11111);
        tick(); j = 0;
        lit_ctl("j_fl1_ctl", 5'b01111);
        cmp("j_fl1_state", a_st, 1);
        tick();
        lit_ctl("j_fl2_ctl", 5'b01111);
        cmp("j_fl2_state", a_st, 1);
        tick();
        lit_ctl("j_run_ctl", 5'b11100);
        cmp("j_run_state", a_st, 0);
        cmp("j_flush", a_fc, 1);
        cmp("j_stall", a_sc, 4);

        // Branch beats load-use; MemBusy during FLUSH freezes the countdown
        br = 1; memread = 1; rt_ex = 8; rs = 8;
        lit_ctl("br_lu_ctl", 5'b11111);
        tick(); br = 0; memread = 0;
        cmp("br_fl1_state", a_st, 1);
        tick(); membusy = 1;
        lit_ctl("busy_ctl", 5'b00000);
        tick(); tick(); tick(); membusy = 0;
        lit_ctl("br_fl2_ctl", 5'b01111);
        cmp("br_fl2_state", a_st, 1);
        tick();
        lit_ctl("br_run_ctl", 5'b11100);
        cmp("br_run_state", a_st, 0);
        cmp("br_stall", a_sc, 9);
        cmp("br_flush", a_fc, 2);

        // Reset in the second FLUSH cycle
        j = 1;
        tick(); j = 0;
        tick();
        #2 reset = 1;
        lit_ctl("rst_mid_ctl", 5'b00000);
        cmp("rst_mid_state", a_st, 0);
        cmp("rst_mid_stall", a_sc, 0);
        cmp("rst_mid_flush", a_fc, 0);
        tick(); reset = 0;
        lit_ctl("rst_rel_ctl", 5'b11100);
        cmp("rst_rel_state", a_st, 0);

        // 20 stalls: 4-bit counter saturates
        memread = 1; rt_ex = 8; rs = 8;
        repeat (20) tick();
        memread = 0;
        #1;
        cmp("sat_a_stall", a_sc, 20);
        cmp("sat_b_stall", b_sc, 15);

        // Single-cycle squash instance never enters FLUSH
        j = 1;
        tick(); j = 0;
        #1;
        cmp("b_j_state", b_st, 0);
        cmp("b_j_ctl", {b_pc, b_if, b_ex, b_fif, b_fex}, 5'b11100);
        cmp("b_j_flush", b_fc, 1);
        repeat (3) tick();

        // Redirect held during MemBusy is accepted once
        membusy = 1; j = 1;
        lit_ctl("busy_j_ctl", 5'b00000);
        tick(); tick(); membusy = 0;
        lit_ctl("busy_j_release_ctl", 5'b11111);
        tick(); j = 0;
        #1;
        cmp("busy_j_a_flush", a_fc, 2);
        cmp("busy_j_b_flush", b_fc, 2);
        cmp("busy_j_a_state", a_st, 1);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
